// File: rtl/velocity_scheduler_pkg.sv
// Shared types and defaults for the lane velocity scheduler: FSM encoding,
// random-source width and default velocity format.
package velocity_scheduler_pkg;

  localparam int RAND_W       = 4;
  localparam int VEL_W_DEF    = 6;
  localparam int VEL_BASE_DEF = 20;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    LOAD = 2'd2
  } state_t;

endpackage

// File: rtl/velocity_scheduler_rr_arbiter.sv
// Rotating-priority encoder: picks the first set request bit starting at ptr
// and scanning upward modulo n_lanes.
module rr_arbiter #(
  parameter int N_LANES = 4,
  parameter int IDX_W   = 2
) (
  input  logic [N_LANES-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [N_LANES-1:0] onehot,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  int j;

  // NOTE: every output gets a default before the loop so no path leaves a
  // value unassigned, which would otherwise infer a latch.
  always_comb begin
    onehot = '0;
    idx    = '0;
    any    = 1'b0;
    j      = 0;
    for (int k = 0; k < N_LANES; k++) begin
      j = (int'(ptr) + k) % N_LANES;
      if (!any && req[j]) begin
        any       = 1'b1;
        idx       = IDX_W'(j);
        onehot[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/velocity_scheduler.sv
// Spawn-tick divider plus a three-state grant FSM that hands the shared random
// velocity to one requesting lane per tick in round-robin order.
module velocity_scheduler
  import velocity_scheduler_pkg::*;
#(
  parameter int N_LANES  = 4,
  parameter int TICK_DIV = 25000000,
  parameter int VEL_W    = VEL_W_DEF,
  parameter int VEL_BASE = VEL_BASE_DEF
) (
  input  logic                       CLK_50MHz,
  input  logic                       reset,
  input  logic                       enable,
  input  logic [N_LANES-1:0]         req,
  input  logic [RAND_W-1:0]          rand_in,
  output logic [N_LANES-1:0]         grant,
  output logic [N_LANES*VEL_W-1:0]   velocity,
  output logic [N_LANES-1:0]         vel_valid,
  output logic                       spawn_tick,
  output logic                       busy
);

  localparam int IDX_W = (N_LANES > 1) ? $clog2(N_LANES) : 1;
  localparam int CNT_W = $clog2(TICK_DIV);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [IDX_W-1:0]     ptr;
  logic [IDX_W-1:0]     win_idx;
  logic [N_LANES-1:0]   win_oh;
  logic [N_LANES-1:0]   req_q;
  logic [N_LANES-1:0]   req_rise;
  logic [N_LANES-1:0]   arb_oh;
  logic [IDX_W-1:0]     arb_idx;
  logic                 arb_any;

  assign spawn_tick = enable && (cnt == CNT_W'(TICK_DIV - 1));
  assign req_rise   = req & ~req_q;

  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge CLK_50MHz or negedge reset) begin
    if (!reset)
      cnt <= '0;
    else if (!enable || spawn_tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  rr_arbiter #(
    .N_LANES (N_LANES),
    .IDX_W   (IDX_W)
  ) u_arb (
    .req    (req),
    .ptr    (ptr),
    .onehot (arb_oh),
    .idx    (arb_idx),
    .any    (arb_any)
  );

  // NOTE: the velocity registers are reset as well, since downstream lanes
  // must see zero velocity after reset rather than stale data.
  always_ff @(posedge CLK_50MHz or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      busy      <= 1'b0;
      ptr       <= '0;
      win_idx   <= '0;
      win_oh    <= '0;
      grant     <= '0;
      velocity  <= '0;
      vel_valid <= '0;
      req_q     <= '0;
    end else begin
      grant     <= '0;
      req_q     <= req;
      vel_valid <= vel_valid & ~req_rise;
      case (state)
        IDLE: begin
          if (spawn_tick && arb_any) begin
            state   <= ARB;
            busy    <= 1'b1;
            win_idx <= arb_idx;
            win_oh  <= arb_oh;
          end
        end
        ARB: state <= LOAD;
        LOAD: begin
          state <= IDLE;
          busy  <= 1'b0;
          grant <= win_oh;
          velocity[win_idx*VEL_W +: VEL_W] <= VEL_W'(rand_in) + VEL_W'(VEL_BASE);
          // A load in the same cycle as a request edge leaves the lane valid.
          vel_valid <= (vel_valid & ~req_rise) | win_oh;
          ptr <= (win_idx == IDX_W'(N_LANES - 1)) ? '0 : win_idx + 1'b1;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_velocity_scheduler.sv
// Self-checking bench: directed scenarios plus random traffic, all compared
// cycle by cycle against an event-level model of the scheduler.
module tb_velocity_scheduler;

  localparam int N  = 4;
  localparam int TD = 8;
  localparam int VW = 6;
  localparam int VB = 20;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          enable = 1'b0;
  logic [N-1:0]  req = '0;
  logic [3:0]    rand_in = '0;
  logic [N-1:0]  grant;
  logic [N*VW-1:0] velocity;
  logic [N-1:0]  vel_valid;
  logic          spawn_tick;
  logic          busy;

  always #10 clk = ~clk;

  velocity_scheduler #(
    .N_LANES  (N),
    .TICK_DIV (TD),
    .VEL_W    (VW),
    .VEL_BASE (VB)
  ) dut (
    .CLK_50MHz  (clk),
    .reset      (reset),
    .enable     (enable),
    .req        (req),
    .rand_in    (rand_in),
    .grant      (grant),
    .velocity   (velocity),
    .vel_valid  (vel_valid),
    .spawn_tick (spawn_tick),
    .busy       (busy)
  );

  // Reference model: divider as an integer, a pending grant with an age.
  int        m_div, m_age, m_lane, m_ptr;
  bit        m_pend;
  int        m_vel [N];
  logic [N-1:0] m_grant, m_valid, m_prev_req;

  int tests, fails, cyc, last_tick, last_lat, tick_count;
  int glog [$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic clear_model();
    m_div = 0; m_age = 0; m_lane = 0; m_ptr = 0; m_pend = 0;
    for (int i = 0; i < N; i++) m_vel[i] = 0;
    m_grant = '0; m_valid = '0; m_prev_req = '0;
  endtask

  function automatic logic [N*VW-1:0] exp_vel();
    logic [N*VW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[i*VW +: VW] = VW'(m_vel[i]);
    return v;
  endfunction

  function automatic int oh_idx(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Advance the model across one rising edge using the current inputs.
  task automatic model_edge();
    logic [N-1:0] rise, set;
    bit tick;
    if (!reset) return;
    rise = req & ~m_prev_req;
    set = '0;
    tick = enable && (m_div == TD - 1);
    m_grant = '0;
    if (m_pend) begin
      if (m_age == 1) begin
        m_vel[m_lane] = int'(rand_in) + VB;
        m_grant = N'(1) << m_lane;
        set = m_grant;
        m_ptr = (m_lane + 1) % N;
        m_pend = 0;
      end else begin
        m_age++;
      end
    end else if (tick && req != '0) begin
      for (int k = N - 1; k >= 0; k--)
        if (req[(m_ptr + k) % N]) m_lane = (m_ptr + k) % N;
      m_pend = 1;
      m_age = 0;
    end
    m_valid = (m_valid & ~rise) | set;
    m_prev_req = req;
    m_div = enable ? ((m_div == TD - 1) ? 0 : m_div + 1) : 0;
  endtask

  task automatic cycle();
    model_edge();
    @(posedge clk);
    @(negedge clk);
    cyc++;
    check("grant", grant, m_grant);
    check("busy", busy, m_pend);
    check("spawn_tick", spawn_tick, enable && (m_div == TD - 1));
    check("vel_valid", vel_valid, m_valid);
    check("velocity", velocity, exp_vel());
    if (spawn_tick) begin
      last_tick = cyc;
      tick_count++;
    end
    if (grant != '0) begin
      glog.push_back(oh_idx(grant));
      last_lat = cyc - last_tick;
    end
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    check("rst_grant", grant, 0);
    check("rst_velocity", velocity, 0);
    check("rst_vel_valid", vel_valid, 0);
    check("rst_spawn_tick", spawn_tick, 0);
    check("rst_busy", busy, 0);
    clear_model();
    repeat (2) cycle();
    reset = 1'b1;
  endtask

  task automatic run_until(input int n, input int budget);
    for (int i = 0; i < budget && glog.size() < n; i++) cycle();
    check("grant_timeout", glog.size(), n);
  endtask

  task automatic wait_arb(input int budget);
    bit found;
    found = 0;
    for (int i = 0; i < budget && !found; i++) begin
      cycle();
      found = m_pend && (m_age == 0);
    end
    check("arb_reach", found, 1);
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0; last_tick = 0; last_lat = 0; tick_count = 0;
    clear_model();
    @(negedge clk);
    enable = 1'b1;
    apply_reset();

    // Idle: ticks every TD cycles, nothing granted.
    tick_count = 0;
    repeat (4 * TD) cycle();
    check("idle_ticks", tick_count, 4);
    check("idle_grants", glog.size(), 0);

    // Single lane 2 with rand 7.
    rand_in = 4'd7;
    req = 4'b0100;
    run_until(1, 3 * TD);
    req = '0;
    repeat (2) cycle();
    check("single_lane", glog[0], 2);
    check("single_latency", last_lat, 3);
    check("lane2_vel", velocity[2*VW +: VW], 27);
    check("single_valid", vel_valid, 4'b0100);

    // Wrap and skip from ptr=3.
    glog.delete();
    req = 4'b0110;
    run_until(3, 5 * TD);
    req = '0;
    cycle();
    check("wrap_0", glog[0], 1);
    check("wrap_1", glog[1], 2);
    check("wrap_2", glog[2], 1);

    // Round robin over all lanes with rand 0,5,10,15.
    apply_reset();
    glog.delete();
    req = 4'b1111;
    for (int i = 0; i < 7 * TD && glog.size() < 5; i++) begin
      rand_in = 4'(5 * (glog.size() % 4));
      cycle();
    end
    req = '0;
    check("rr_count", glog.size(), 5);
    check("rr_0", glog[0], 0);
    check("rr_1", glog[1], 1);
    check("rr_2", glog[2], 2);
    check("rr_3", glog[3], 3);
    check("rr_wrap", glog[4], 0);
    check("rr_vel", velocity, {6'd35, 6'd30, 6'd25, 6'd20});

    // Enable drops while the FSM is in ARB: the grant still completes.
    req = 4'b0010;
    wait_arb(2 * TD);
    enable = 1'b0;
    glog.delete();
    tick_count = 0;
    repeat (3 * TD) cycle();
    check("en_off_grant", glog.size(), 1);
    check("en_off_lane", glog[0], 1);
    check("en_off_ticks", tick_count, 0);
    enable = 1'b1;

    // Reset pulse during ARB aborts; first tick afterwards grants lane 0.
    req = 4'b1111;
    wait_arb(2 * TD);
    glog.delete();
    apply_reset();
    check("abort_no_grant", glog.size(), 0);
    run_until(1, 2 * TD);
    check("post_rst_lane", glog[0], 0);
    req = '0;

    // Random traffic.
    repeat (600) begin
      req = N'($urandom);
      rand_in = 4'($urandom);
      enable = ($urandom_range(0, 9) != 0);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
